fetch_queue_unit: RTL and testbench

// - Parametrised instruction-fetch stage for the MIPS core; replaces the free-running PC register.
// - Owns the PC and issues word-addressed fetches to instruction memory (combinational read data).
// - Buffers {pc, instr} pairs in a DEPTH-entry FIFO toward decode with a valid/ready handshake.
// - Accepts redirects (branch/j/jr resolved downstream), which flush the queue.

---
 rtl/fetch_queue_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the PC, fetches from imem and queues {pc, instr} toward decode.
// Define FETCH_RAS_EN to build j/jal/jr $31 predecode with a return-address stack.
module fetch_queue_unit #(
  parameter int PC_W      = 32,
  parameter int DEPTH     = 4,
  parameter int PC_INC    = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  output logic [PC_W-1:0]              imem_addr,
  output logic                         imem_req,
  input  logic                         imem_ready,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [PC_W-1:0]              out_pc,
  output logic                         out_pred,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PC_W-1:0]  pc_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PC_W-1:0]  q_pc_r    [DEPTH];
  logic [31:0]      q_instr_r [DEPTH];

  logic             req_s;
  logic             push_s;
  logic             pop_s;
  logic             out_valid_s;
  logic [PC_W-1:0]  seq_pc_s;
  logic [PC_W-1:0]  next_pc_s;

  assign out_valid_s = (count_r != CNT_W'(0));
  assign seq_pc_s    = pc_r + PC_W'(PC_INC);
  assign push_s      = req_s & imem_ready;
  assign pop_s       = out_valid_s & out_ready & ~redirect_valid;

  // Fetch request: room in the queue now, or a slot freed by this cycle's pop.
  always_comb begin
    req_s = 1'b0;
    if (reset_n && !redirect_valid) begin
      req_s = (count_r < CNT_W'(DEPTH)) | (out_valid_s & out_ready);
    end else begin
      req_s = 1'b0;
    end
  end

  // PC, queue pointers and occupancy; redirect flushes and wins over push/pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_r     <= RESET_PC;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (redirect_valid) begin
      pc_r     <= redirect_pc;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        pc_r     <= next_pc_s;
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue payload storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push_s) begin
      q_pc_r[wr_ptr_r]    <= pc_r;
      q_instr_r[wr_ptr_r] <= imem_rdata;
    end
  end

`ifdef FETCH_RAS_EN
  localparam int RAS_W = $clog2(RAS_DEPTH);
  localparam int RC_W  = $clog2(RAS_DEPTH+1);

  logic [PC_W-1:0]  ras_r [RAS_DEPTH];
  logic [RAS_W-1:0] ras_top_r;
  logic [RC_W-1:0]  ras_cnt_r;
  logic             pred_next_r;
  logic             q_pred_r [DEPTH];
  logic             taken_s;
  logic             ras_push_s;
  logic             ras_pop_s;
  logic             is_jr31_s;

  assign is_jr31_s = (imem_rdata[31:26] == 6'h00) && (imem_rdata[5:0] == 6'h08) &&
                     (imem_rdata[25:21] == 5'd31);

  // Predecode of the word being fetched selects the next PC.
  always_comb begin
    next_pc_s  = seq_pc_s;
    taken_s    = 1'b0;
    ras_push_s = 1'b0;
    ras_pop_s  = 1'b0;
    if ((imem_rdata[31:26] == 6'h02) || (imem_rdata[31:26] == 6'h03)) begin
      next_pc_s  = PC_W'(imem_rdata[25:0]);
      taken_s    = 1'b1;
      ras_push_s = (imem_rdata[31:26] == 6'h03);
    end else if (is_jr31_s && (ras_cnt_r != RC_W'(0))) begin
      next_pc_s = ras_r[ras_top_r - RAS_W'(1)];
      taken_s   = 1'b1;
      ras_pop_s = 1'b1;
    end else begin
      next_pc_s = seq_pc_s;
    end
  end

  // RAS pointers and the pred flag carried to the entry fetched after a transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ras_top_r   <= '0;
      ras_cnt_r   <= '0;
      pred_next_r <= 1'b0;
    end else if (redirect_valid) begin
      pred_next_r <= 1'b0;
    end else if (push_s) begin
      pred_next_r <= taken_s;
      if (ras_push_s) begin
        ras_top_r <= ras_top_r + RAS_W'(1);
        // A full stack wraps and overwrites its oldest entry.
        ras_cnt_r <= (ras_cnt_r == RC_W'(RAS_DEPTH)) ? ras_cnt_r : ras_cnt_r + RC_W'(1);
      end else if (ras_pop_s) begin
        ras_top_r <= ras_top_r - RAS_W'(1);
        ras_cnt_r <= ras_cnt_r - RC_W'(1);
      end else begin
        ras_top_r <= ras_top_r;
      end
    end else begin
      pred_next_r <= pred_next_r;
    end
  end

  // RAS and pred-bit payload storage.
  always_ff @(posedge clock) begin
    if (push_s) begin
      q_pred_r[wr_ptr_r] <= pred_next_r;
      if (ras_push_s) begin
        ras_r[ras_top_r] <= seq_pc_s;
      end
    end
  end

  assign out_pred = q_pred_r[rd_ptr_r];
`else
  logic unused_ras_cfg_s;

  assign unused_ras_cfg_s = (RAS_DEPTH > 0);
  assign next_pc_s        = seq_pc_s;
  assign out_pred         = 1'b0;
`endif

  assign imem_addr = pc_r;
  assign imem_req  = req_s;
  assign out_valid = out_valid_s;
  assign out_pc    = q_pc_r[rd_ptr_r];
  assign out_instr = q_instr_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit (PC_W=8, DEPTH=4): vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_fetch_queue_unit;

  logic        clock;
  logic        reset_n;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        out_pred;
  logic [2:0]  count;
  logic        ras_mode;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue_unit #(.PC_W(8), .DEPTH(4), .PC_INC(1), .RESET_PC(8'h00), .RAS_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pred(out_pred), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory: mem[a] = 0x100 + a, plus a small jal/jr program when ras_mode is set.
  always_comb begin
    imem_rdata = 32'h100 + {24'h0, imem_addr};
    if (ras_mode) begin
      if (imem_addr == 8'h10) imem_rdata = 32'h0C00_0080;
      else if (imem_addr == 8'h82) imem_rdata = 32'h03E0_0008;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic o_r, input logic i_r, input logic rv, input logic [7:0] rpc);
    out_ready      = o_r;
    imem_ready     = i_r;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  typedef struct {
    logic       o_r, i_r, rv;
    logic [7:0] rpc;
    logic       req_e;
    logic [7:0] addr_e;
    logic       valid_e;
    logic [7:0] pc_e;
    logic [2:0] cnt_e;
  } vec_t;

  vec_t tbl [16];

  int          m_pc;
  logic [39:0] mq [$];
  logic [7:0]  seen_pc [$];
  logic        seen_pred [$];
  logic [7:0]  exp_pc [5];
  logic [4:0]  exp_pred;
  logic [7:0]  wrap_addr [4];
  logic        m_req, m_push, m_pop;

  initial begin
    // Fill to full with decode stalled, drain in order, then flush with three entries held.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00, 3'd1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h00, 3'd2};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h00, 3'd3};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 8'h00, 3'd4};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 8'h00, 3'd4};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h00, 3'd4};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h01, 3'd4};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 8'h02, 3'd4};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 8'h03, 3'd4};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 1'b1, 8'h04, 3'd4};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h09, 1'b1, 8'h05, 3'd4};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h09, 1'b1, 8'h06, 3'd3};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 3'd0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 8'h40, 3'd1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 8'h00, 3'd0};

    ras_mode = 1'b0;
    reset_n  = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (2) @(negedge clock);
    #1;
    chk("rst_addr", {24'h0, imem_addr}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_count", {29'h0, count}, 32'h0);
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      drive(tbl[i].o_r, tbl[i].i_r, tbl[i].rv, tbl[i].rpc);
      #1;
      chk($sformatf("tbl%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].req_e});
      chk($sformatf("tbl%0d_addr", i), {24'h0, imem_addr}, {24'h0, tbl[i].addr_e});
      chk($sformatf("tbl%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].valid_e});
      chk($sformatf("tbl%0d_count", i), {29'h0, count}, {29'h0, tbl[i].cnt_e});
      if (tbl[i].valid_e) begin
        chk($sformatf("tbl%0d_pc", i), {24'h0, out_pc}, {24'h0, tbl[i].pc_e});
        chk($sformatf("tbl%0d_instr", i), out_instr, 32'h100 + {24'h0, tbl[i].pc_e});
      end
    end

    // PC wrap at 2^8: redirect to 0xFE, then fetch 0xFE, 0xFF, 0x00, 0x01.
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b1, 8'hFE);
    wrap_addr[0] = 8'hFE; wrap_addr[1] = 8'hFF; wrap_addr[2] = 8'h00; wrap_addr[3] = 8'h01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      #1;
      chk($sformatf("wrap%0d_addr", k), {24'h0, imem_addr}, {24'h0, wrap_addr[k]});
      chk($sformatf("wrap%0d_valid", k), {31'h0, out_valid}, (k == 0) ? 32'h0 : 32'h1);
      if (k > 0) begin
        chk($sformatf("wrap%0d_pc", k), {24'h0, out_pc}, {24'h0, wrap_addr[k-1]});
        chk($sformatf("wrap%0d_instr", k), out_instr, 32'h100 + {24'h0, wrap_addr[k-1]});
      end
    end

    // jal 0x80 at 0x10, jr $31 at 0x82.
    @(negedge clock);
    ras_mode = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'h10);
`ifdef FETCH_RAS_EN
    exp_pc[0] = 8'h10; exp_pc[1] = 8'h80; exp_pc[2] = 8'h81; exp_pc[3] = 8'h82; exp_pc[4] = 8'h11;
    exp_pred = 5'b10010;
`else
    exp_pc[0] = 8'h10; exp_pc[1] = 8'h11; exp_pc[2] = 8'h12; exp_pc[3] = 8'h13; exp_pc[4] = 8'h14;
    exp_pred = 5'b00000;
`endif
    for (int c = 0; c < 20 && seen_pc.size() < 5; c++) begin
      @(negedge clock);
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      #1;
      if (out_valid) begin
        seen_pc.push_back(out_pc);
        seen_pred.push_back(out_pred);
      end
    end
    chk("ras_entries", seen_pc.size(), 32'd5);
    for (int k = 0; k < 5 && k < seen_pc.size(); k++) begin
      chk($sformatf("ras%0d_pc", k), {24'h0, seen_pc[k]}, {24'h0, exp_pc[k]});
      chk($sformatf("ras%0d_pred", k), {31'h0, seen_pred[k]}, {31'h0, exp_pred[k]});
    end
    @(negedge clock);
    ras_mode = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 8'h20);
    m_pc = 32'h20;
    mq.delete();

    // Random traffic against the reference queue model, with one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (i == 200) begin
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b0;
        for (int r = 0; r < 2; r++) begin
          #1;
          chk("midrst_addr", {24'h0, imem_addr}, 32'h0);
          chk("midrst_req", {31'h0, imem_req}, 32'h0);
          chk("midrst_valid", {31'h0, out_valid}, 32'h0);
          chk("midrst_count", {29'h0, count}, 32'h0);
          @(negedge clock);
        end
        reset_n = 1'b1;
        m_pc = 0;
        mq.delete();
        continue;
      end
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 24) == 0, 8'($urandom));
      #1;
      m_req = !redirect_valid && (mq.size() < 4 || (mq.size() > 0 && out_ready));
      chk("rnd_addr", {24'h0, imem_addr}, m_pc);
      chk("rnd_req", {31'h0, imem_req}, {31'h0, m_req});
      chk("rnd_count", {29'h0, count}, mq.size());
      chk("rnd_valid", {31'h0, out_valid}, (mq.size() > 0) ? 32'h1 : 32'h0);
      if (mq.size() > 0) begin
        chk("rnd_pc", {24'h0, out_pc}, {24'h0, mq[0][39:32]});
        chk("rnd_instr", out_instr, mq[0][31:0]);
      end
      if (redirect_valid) begin
        m_pc = redirect_pc;
        mq.delete();
      end else begin
        m_pop  = (mq.size() > 0) && out_ready;
        m_push = m_req && imem_ready;
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back({8'(m_pc), 32'h100 + m_pc});
          m_pc = (m_pc + 1) % 256;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
